wb_arb_2to1: RTL and testbench

WB_ARB_2TO1 -- requirements
Module: wb_arb_2to1

---
 rtl/wb_arb_2to1.sv | 143 ++++++++++++++
 tb/tb_wb_arb_2to1.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_2to1.sv
// Two-master to one-slave pipelined Wishbone arbiter (instruction master 0, data master 1).
// Latency: one-cycle grant from IDLE; once granted, request and response paths are combinational.
// Backpressure: owner stalls on s_stall or when MAX_OUTST requests are outstanding; non-owner always stalled.
// Optional macro WB_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: data master wins).
module wb_arb_2to1 #(
  parameter int ADR_W     = 28,
  parameter int MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         m_cyc,
  input  logic [1:0]         m_stb,
  input  logic [1:0]         m_we,
  input  logic [2*ADR_W-1:0] m_adr,
  input  logic [7:0]         m_sel,
  input  logic [63:0]        m_dat_w,
  output logic [1:0]         m_ack,
  output logic [1:0]         m_err,
  output logic [1:0]         m_stall,
  output logic [31:0]        m_dat_r,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [3:0]         s_sel,
  output logic [31:0]        s_dat_w,
  input  logic               s_ack,
  input  logic               s_err,
  input  logic               s_stall,
  input  logic [31:0]        s_dat_r
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       owned;     // some master holds the bus
  logic       own;       // index of the owner (valid when owned)
  logic       own_cyc;   // owner is still keeping its cycle open
  logic       full;      // outstanding limit reached
  logic       issue;     // request accepted by the slave this cycle
  logic       resp;      // response that belongs to a live outstanding request
  logic       grant;     // master picked when leaving IDLE

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last;            // master granted most recently

  // Remember who was granted last so simultaneous requests alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b0;
    else if (state == IDLE && |m_cyc)
      last <= grant;
  end

  // Simultaneous requests go to the master not served most recently.
  always_comb begin
    grant = m_cyc[1];
    if (m_cyc == 2'b11)
      grant = ~last;
  end
`else
  // Fixed priority: the data master wins any tie.
  always_comb begin
    grant = m_cyc[1];
  end
`endif

  // Ownership decode, slave request mux and response routing.
  always_comb begin
    owned   = (state != IDLE);
    own     = (state == OWN1);
    own_cyc = owned & m_cyc[own];
    full    = (cnt == MAX_CNT);

    s_cyc   = own_cyc;
    s_stb   = own_cyc & m_stb[own] & ~full;
    s_we    = owned & m_we[own];
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    if (owned) begin
      s_adr   = own ? m_adr[2*ADR_W-1:ADR_W] : m_adr[ADR_W-1:0];
      s_sel   = own ? m_sel[7:4]             : m_sel[3:0];
      s_dat_w = own ? m_dat_w[63:32]         : m_dat_w[31:0];
    end

    issue = s_stb & ~s_stall;
    // Responses with nothing outstanding (spurious, or after an abort) are dropped.
    resp  = own_cyc & (s_ack | s_err) & (cnt != 3'd0);

    m_ack   = 2'b00;
    m_err   = 2'b00;
    m_stall = 2'b11;
    if (owned) begin
      m_ack[own]   = resp & s_ack;
      m_err[own]   = resp & s_err;
      m_stall[own] = s_stall | full;
    end

    m_dat_r = s_dat_r;
  end

  // Next-state and outstanding-count logic; ownership only changes via IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (|m_cyc)
          state_nxt = grant ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          // Owner ended or aborted its cycle: forget anything still in flight.
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + {2'b00, issue} - {2'b00, resp};
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arb_2to1.sv
// Directed bench for wb_arb_2to1 with a latency-programmable slave model and a read-data scoreboard.
module tb_wb_arb_2to1;
  localparam int ADR_W     = 28;
  localparam int MAX_OUTST = 4;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] CONT2_STALL = 2'b10;  // master 0 owns second round
`else
  localparam logic [1:0] CONT2_STALL = 2'b01;  // master 1 owns again
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         m_cyc, m_stb, m_we;
  logic [2*ADR_W-1:0] m_adr;
  logic [7:0]         m_sel;
  logic [63:0]        m_dat_w;
  logic [1:0]         m_ack, m_err, m_stall;
  logic [31:0]        m_dat_r;
  logic               s_cyc, s_stb, s_we;
  logic [ADR_W-1:0]   s_adr;
  logic [3:0]         s_sel;
  logic [31:0]        s_dat_w;
  logic               s_ack, s_err, s_stall;
  logic [31:0]        s_dat_r;

  wb_arb_2to1 #(.ADR_W(ADR_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel), .m_dat_w(m_dat_w),
    .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel), .s_dat_w(s_dat_w),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall), .s_dat_r(s_dat_r)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt [2] = '{0, 0};
  int cyc_no = 0;
  int a0, a1;

  typedef struct { int due; logic [31:0] dat; } pend_t;
  pend_t       pend_q [$];     // slave: responses waiting to be returned
  logic [32:0] exp_q  [$];     // scoreboard: {master, read data}
  bit          slave_en  = 1'b0;
  int          slave_lat = 2;

  function automatic logic [31:0] rd_dat(input logic [ADR_W-1:0] a);
    return {4'hD, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Raise stb for master m and hold it until the arbiter accepts it; returns one cycle later, stb still high.
  task automatic issue(input int m, input logic [ADR_W-1:0] a);
    bit done;
    done = 1'b0;
    m_stb[m] = 1'b1;
    if (m == 0) m_adr[ADR_W-1:0] = a;
    else        m_adr[2*ADR_W-1:ADR_W] = a;
    for (int t = 0; t < 50 && !done; t++) begin
      if (!m_stall[m]) begin
        exp_q.push_back({m[0], rd_dat(a)});
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL issue_timeout: observed stall for 50 cycles expected accept (master %0d)", m);
    end
  endtask

  // Slave response driver: one response per cycle, fixed latency after acceptance.
  initial forever begin
    @(posedge clk);
    cyc_no++;
    #1;
    if (slave_en) begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc_no) begin
        s_ack   = 1'b1;
        s_dat_r = pend_q[0].dat;
        pend_q.delete(0);
      end else begin
        s_ack   = 1'b0;
        s_dat_r = 32'hDEAD_BEEF;
      end
    end
  end

  // Slave acceptance sampler and master-side scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (slave_en && !rst && s_cyc && s_stb && !s_stall)
      pend_q.push_back('{cyc_no + slave_lat, rd_dat(s_adr)});
    for (int i = 0; i < 2; i++) begin
      if (m_ack[i]) begin
        logic [32:0] e;
        ack_cnt[i]++;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_ack: observed ack on master %0d expected none", i);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ack_master", i, {31'd0, e[32]});
          chk("rd_data", m_dat_r, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = 8'hFF; m_dat_w = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_dat_r = 32'h1234_5678;

    // Reset state, before any clock edge.
    #3;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_stall", m_stall, 2'b11);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_cnt", dut.cnt, 0);
    chk("dat_r_bcast", m_dat_r, 32'h1234_5678);
    @(posedge clk); #2;
    rst = 1'b0;
    tick();

    // Contention straight out of reset.
    m_cyc = 2'b11;
    chk("cont_idle_s_cyc", s_cyc, 0);
    tick();
    chk("cont_first_own1", m_stall, 2'b01);
    chk("cont_first_s_cyc", s_cyc, 1);
    m_cyc = 2'b01;
    tick();
    chk("cont_gap_s_cyc", s_cyc, 0);
    chk("cont_gap_stall", m_stall, 2'b11);
    m_cyc = 2'b11;
    tick();
    chk("cont_second_owner", m_stall, CONT2_STALL);
    m_cyc = 2'b00;
    tick();
    chk("cont_end_stall", m_stall, 2'b11);

    // Single read by master 0, slave latency 2.
    slave_en = 1'b1; slave_lat = 2;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    m_cyc = 2'b01; m_stb = 2'b01; m_adr[ADR_W-1:0] = 28'h100;
    chk("single_idle_s_cyc", s_cyc, 0);
    tick();
    chk("single_s_cyc", s_cyc, 1);
    chk("single_s_adr", s_adr, 32'h100);
    chk("single_s_stb", s_stb, 1);
    chk("single_stall", m_stall, 2'b10);
    issue(0, 28'h100);
    m_stb = 2'b00;
    repeat (4) tick();
    chk("single_ack0", ack_cnt[0] - a0, 1);
    chk("single_ack1", ack_cnt[1] - a1, 0);
    chk("single_sb_empty", exp_q.size(), 0);
    m_cyc = 2'b00;
    tick();
    chk("single_idle_again", s_cyc, 0);
    chk("single_idle_stall", m_stall, 2'b11);

    // Pipelined burst of 6, slave latency 5, limit 4 outstanding.
    slave_lat = 5;
    a0 = ack_cnt[0];
    m_cyc = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) issue(0, 28'h200 + 28'(i));
    chk("burst_full_stall", m_stall, 2'b11);
    chk("burst_full_stb", s_stb, 0);
    chk("burst_full_cnt", dut.cnt, 4);
    for (int i = 4; i < 6; i++) issue(0, 28'h200 + 28'(i));
    m_stb = 2'b00;
    repeat (12) tick();
    chk("burst_acks", ack_cnt[0] - a0, 6);
    chk("burst_cnt_end", dut.cnt, 0);
    chk("burst_sb_empty", exp_q.size(), 0);
    m_cyc = 2'b00;
    tick();

    // Abort with two outstanding; the late acks must be dropped.
    slave_lat = 4;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    m_cyc = 2'b01;
    tick();
    issue(0, 28'h280);
    issue(0, 28'h281);
    m_stb = 2'b00;
    chk("abort_cnt2", dut.cnt, 2);
    m_cyc = 2'b00;
    tick();
    chk("abort_cnt0", dut.cnt, 0);
    chk("abort_s_cyc", s_cyc, 0);
    chk("abort_stall", m_stall, 2'b11);
    exp_q.delete();
    repeat (6) tick();
    chk("abort_no_ack0", ack_cnt[0] - a0, 0);
    chk("abort_no_ack1", ack_cnt[1] - a1, 0);

    // Spurious responses in IDLE and in OWN0 with nothing outstanding.
    slave_en = 1'b0;
    s_ack = 1'b1;
    chk("spur_idle_ack", m_ack, 0);
    tick();
    chk("spur_idle_cnt", dut.cnt, 0);
    s_ack = 1'b0;
    m_cyc = 2'b01;
    tick();
    s_ack = 1'b1;
    chk("spur_own_ack", m_ack, 0);
    tick();
    chk("spur_own_cnt", dut.cnt, 0);
    s_ack = 1'b0; s_err = 1'b1;
    chk("spur_own_err", m_err, 0);
    tick();
    s_err = 1'b0;
    chk("spur_own_cnt2", dut.cnt, 0);
    m_cyc = 2'b00;
    tick();

    // Asynchronous reset in the middle of a burst.
    slave_en = 1'b1; slave_lat = 3;
    m_cyc = 2'b01;
    tick();
    issue(0, 28'h300);
    issue(0, 28'h301);
    #1 rst = 1'b1;
    #1;
    chk("arst_s_cyc", s_cyc, 0);
    chk("arst_s_stb", s_stb, 0);
    chk("arst_stall", m_stall, 2'b11);
    chk("arst_ack", m_ack, 0);
    chk("arst_cnt", dut.cnt, 0);
    slave_en = 1'b0;
    pend_q.delete();
    exp_q.delete();
    s_ack = 1'b0; m_stb = 2'b00; m_cyc = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    slave_en = 1'b1; slave_lat = 2;
    a1 = ack_cnt[1];
    m_cyc = 2'b10;
    tick();
    chk("post_rst_stall", m_stall, 2'b01);
    chk("post_rst_s_cyc", s_cyc, 1);
    issue(1, 28'h3A5);
    m_stb = 2'b00;
    repeat (5) tick();
    chk("post_rst_ack1", ack_cnt[1] - a1, 1);
    chk("post_rst_sb_empty", exp_q.size(), 0);
    m_cyc = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
